irq_controller: RTL and testbench

Parametrised interrupt controller between peripheral interrupt sources and `cpu_top`'s single `int_req`/`int_ack` pair. It synchronises and latches up to eight sources, applies a per-source enable mask and level/edge mode, and raises `int_req` for the highest-priority pending source. On `int_ack` it presents an 8-bit ISR vector and tracks in-service state until the CPU signals end-of-interrupt on RETI.

---
 rtl/irq_controller.sv | 117 +++++++++++
 tb/tb_irq_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Prioritised, maskable interrupt controller: 2-flop synchronised sources, one vectored request to the CPU.
// Latency: source rise to int_req is 3 edges; int_ack honoured only while int_req is high.
// Optional build macro IRQ_NESTING_EN lets a strictly higher-priority source preempt the one in service.
module irq_controller #(
    parameter int         NUM_IRQ    = 4,
    parameter logic [7:0] VEC_BASE   = 8'h80,
    parameter int         VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata,
    output logic               int_req,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic [7:0]         int_vector
);

    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] sync1, s, s_d;
    logic [NUM_IRQ-1:0] enable, edge_mode, pend_q, in_service;
    logic [NUM_IRQ-1:0] wdata, rise, pending, pend_en;
    logic [NUM_IRQ-1:0] cand_oh, is_low_oh, ack_set, eoi_clr, w1c;
    logic [NUM_IRQ-1:0] rd;
    logic               cand_vld, eligible, ack_ok;
    logic [2:0]         cand_id;
    logic [7:0]         cand_vec;
    logic               unused_wdata;

    assign wdata        = cfg_wdata[NUM_IRQ-1:0];
    assign unused_wdata = ^cfg_wdata;

    // Edge detect is folded into the visible pending value so an edge source
    // requests on the same edge count as a level source.
    assign rise    = s & ~s_d & edge_mode;
    assign pending = (edge_mode & (pend_q | rise)) | (~edge_mode & s);
    assign pend_en = pending & enable;

    assign cand_vld  = |pend_en;
    assign cand_oh   = pend_en & (~pend_en + ONE);
    assign is_low_oh = in_service & (~in_service + ONE);

    assign ack_ok  = int_ack & int_req;
    assign ack_set = ack_ok ? cand_oh : '0;
    assign eoi_clr = int_eoi ? is_low_oh : '0;
    assign w1c     = (cfg_we && cfg_addr == 2'd2) ? wdata : '0;

`ifdef IRQ_NESTING_EN
    // One-hot compare: a smaller one-hot value means a strictly lower index.
    assign eligible = cand_vld && ((in_service == '0) || (cand_oh < is_low_oh));
`else
    assign eligible = cand_vld && (in_service == '0);
`endif

    always_comb begin
        cand_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_en[i]) cand_id = 3'(i);
        end
    end

    assign cand_vec = 8'(int'(VEC_BASE) + int'(cand_id) * VEC_STRIDE);

    always_comb begin
        rd = '0;
        case (cfg_addr)
            2'd0:    rd = enable;
            2'd1:    rd = edge_mode;
            2'd2:    rd = pending;
            default: rd = in_service;
        endcase
        cfg_rdata = '0;
        cfg_rdata[NUM_IRQ-1:0] = rd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            s     <= '0;
            s_d   <= '0;
        end else begin
            sync1 <= irq_in;
            s     <= sync1;
            s_d   <= s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable    <= '0;
            edge_mode <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == 2'd0) enable    <= wdata;
            if (cfg_addr == 2'd1) edge_mode <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= '0;
            in_service <= '0;
            int_req    <= 1'b0;
            int_vector <= 8'h00;
        end else begin
            // New edge wins over W1C / acknowledge clear in the same cycle.
            pend_q     <= ((pend_q & ~w1c & ~ack_set) | rise) & edge_mode;
            in_service <= (in_service & ~eoi_clr) | ack_set;
            int_req    <= eligible & ~ack_ok;
            if (ack_ok) int_vector <= cand_vld ? cand_vec : 8'hFF;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; acknowledge vectors go through a scoreboard queue checked by a monitor.
`timescale 1ns/1ps
module tb_irq_controller;

    localparam int NUM_IRQ = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [7:0]         cfg_wdata;
    logic [7:0]         cfg_rdata;
    logic               int_req;
    logic               int_ack;
    logic               int_eoi;
    logic [7:0]         int_vector;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    irq_controller #(.NUM_IRQ(4), .VEC_BASE(8'h80), .VEC_STRIDE(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .int_req   (int_req),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .int_vector(int_vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0; cfg_wdata = 8'h00;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        check(name, cfg_rdata, exp);
    endtask

    task automatic req_check(input string name, input logic exp);
        check(name, {7'd0, int_req}, {7'd0, exp});
    endtask

    task automatic ack(input logic [7:0] exp_vec);
        exp_q.push_back(exp_vec);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
    endtask

    task automatic eoi();
        int_eoi = 1'b1;
        tick(1);
        int_eoi = 1'b0;
    endtask

    task automatic pulse(input logic [NUM_IRQ-1:0] m);
        irq_in = m;
        tick(1);
        irq_in = '0;
    endtask

    // Monitor: a handshake seen before an edge means the vector is checked after it.
    initial begin
        logic hs;
        hs = 1'b0;
        forever begin
            @(negedge clk);
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL vector: unexpected acknowledge, got %02h expected none", int_vector);
                end else begin
                    check("vector", int_vector, exp_q.pop_front());
                end
            end
            hs = int_ack && int_req && reset_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = 8'h00; int_ack = 1'b0; int_eoi = 1'b0;
        tick(2);
        req_check("reset_req", 1'b0);
        check("reset_vector", int_vector, 8'h00);
        for (int a = 0; a < 4; a++) rd_check("reset_reg", 2'(a), 8'h00);
        reset_n = 1'b1;
        tick(1);

        // Level source 2: request on the 3rd edge, vector 88.
        wr(2'd0, 8'h04);
        irq_in = 4'b0100;
        tick(2);
        req_check("lvl_req_early", 1'b0);
        tick(1);
        req_check("lvl_req_e3", 1'b1);
        ack(8'h88);
        req_check("lvl_req_after_ack", 1'b0);
        rd_check("lvl_in_service", 2'd3, 8'h04);
        irq_in = '0;
        tick(3);
        eoi();
        tick(2);
        req_check("lvl_no_rereq", 1'b0);
        rd_check("lvl_is_cleared", 2'd3, 8'h00);

        // Two edge sources pulsed together: 1 first, 3 after EOI.
        wr(2'd1, 8'h0F);
        wr(2'd0, 8'h0F);
        pulse(4'b1010);
        tick(2);
        req_check("edge_req", 1'b1);
        rd_check("edge_pending", 2'd2, 8'h0A);
        ack(8'h84);
        rd_check("edge_pending_after_ack", 2'd2, 8'h08);
        tick(2);
        req_check("edge_blocked_in_service", 1'b0);
        eoi();
        tick(1);
        req_check("edge_rereq_after_eoi", 1'b1);
        ack(8'h8C);
        eoi();

        // Level source 0 held through EOI re-requests; released before EOI does not.
        wr(2'd1, 8'h00);
        irq_in = 4'b0001;
        tick(3);
        req_check("lvl0_req", 1'b1);
        ack(8'h80);
        tick(2);
        req_check("lvl0_held_no_req", 1'b0);
        eoi();
        req_check("lvl0_eoi_edge", 1'b0);
        tick(1);
        req_check("lvl0_rereq", 1'b1);
        ack(8'h80);
        irq_in = '0;
        tick(3);
        eoi();
        tick(2);
        req_check("lvl0_released_no_req", 1'b0);

        // W1C on edge pending; concurrent new edge wins.
        wr(2'd1, 8'h04);
        wr(2'd0, 8'h04);
        pulse(4'b0100);
        tick(2);
        req_check("w1c_req_before", 1'b1);
        wr(2'd2, 8'h04);
        rd_check("w1c_cleared", 2'd2, 8'h00);
        tick(1);
        req_check("w1c_req_dropped", 1'b0);
        pulse(4'b0100);
        tick(1);
        wr(2'd2, 8'h04);
        rd_check("w1c_set_wins", 2'd2, 8'h04);
        req_check("w1c_set_wins_req", 1'b1);
        wr(2'd2, 8'h04);
        tick(1);
        req_check("w1c_second_clear", 1'b0);

        // Source 3 in service, then source 0 edges.
        wr(2'd1, 8'h0F);
        wr(2'd0, 8'h0F);
        pulse(4'b1000);
        tick(2);
        ack(8'h8C);
        rd_check("nest_is3", 2'd3, 8'h08);
        pulse(4'b0001);
        tick(2);
`ifdef IRQ_NESTING_EN
        req_check("nest_preempt_req", 1'b1);
        ack(8'h80);
        rd_check("nest_is_both", 2'd3, 8'h09);
        eoi();
        rd_check("nest_first_eoi", 2'd3, 8'h08);
        eoi();
`else
        req_check("nonest_blocked", 1'b0);
        tick(3);
        req_check("nonest_still_blocked", 1'b0);
        eoi();
        tick(1);
        req_check("nonest_req_after_eoi", 1'b1);
        ack(8'h80);
        eoi();
`endif
        rd_check("nest_is_empty", 2'd3, 8'h00);

        // Asynchronous reset mid-operation.
        pulse(4'b0010);
        tick(2);
        req_check("rst_pre_req", 1'b1);
        ack(8'h84);
        rd_check("rst_pre_is", 2'd3, 8'h02);
        pulse(4'b0001);
        tick(2);
`ifdef IRQ_NESTING_EN
        req_check("rst_pre_req2", 1'b1);
`else
        req_check("rst_pre_req2", 1'b0);
`endif
        reset_n = 1'b0;
        #1;
        req_check("rst_async_req", 1'b0);
        check("rst_async_vector", int_vector, 8'h00);
        for (int a = 0; a < 4; a++) rd_check("rst_async_reg", 2'(a), 8'h00);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        wr(2'd0, 8'h0F);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tick(1);
        check("idle_ack_vector", int_vector, 8'h00);
        rd_check("idle_ack_is", 2'd3, 8'h00);
        req_check("idle_ack_req", 1'b0);

        tick(3);
        check("pending_acks", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
